mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sits between I-cache/D-cache fill FSMs and the shared pipelined main memory.
//  Grants one requester at a time, forwards its sequential fill addresses or single
//  store, counts memory returns, steers data_valid to the owner, stalls the other.
//  Drives each cache's memory_data_valid and wait inputs; owner sends memory_address.
// PARAMETERS
//  WORDS    8   16-bit words per cache block (fill length)
//  MEM_LAT  4   cycles from mem_enable to matching mem_data_valid (fixed, pipelined)
//  CNT_W    4   counter width, must hold WORDS and MEM_LAT
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  i_req         in   1   I-cache fill request (its fsm_busy)
//  i_addr        in   16  I-cache sequential fill address
//  d_req         in   1   D-cache request (fill or store)
//  d_wr          in   1   with d_req: store (1 word) instead of fill
//  d_addr        in   16  D-cache fill/store address
//  d_wdata       in   16  D-cache store data
//  mem_data_valid in  1   memory read data valid
//  mem_enable    out  1   memory access this cycle
//  mem_wr        out  1   memory write this cycle
//  mem_addr      out  16  memory address
//  mem_wdata     out  16  memory write data (= d_wdata)
//  i_data_valid  out  1   to I-cache memory_data_valid
//  d_data_valid  out  1   to D-cache memory_data_valid
//  i_wait        out  1   to I-cache waitForICACHE: not owner, hold
//  d_wait        out  1   to D-cache: not owner, hold
// BEHAVIOUR
//  States: IDLE, I_FILL, D_FILL, D_WRITE, DRAIN. Reset -> IDLE; all outputs 0,
//   issue_cnt=recv_cnt=0, last_grant=I (so D wins first tie).
//  IDLE: i_wait=i_req&d_req&winner=D, d_wait likewise; no mem access.
//   Winner: single requester wins; both -> the one NOT equal last_grant (round robin).
//   D wins & d_wr -> D_WRITE; D wins & ~d_wr -> D_FILL; I wins -> I_FILL.
//   Transition registered: access begins cycle after grant; last_grant updated.
//  FILL (owner X): mem_enable=1, mem_wr=0, mem_addr=X_addr while issue_cnt<WORDS;
//   issue_cnt++ per issued word. X_data_valid=mem_data_valid (same cycle, comb);
//   recv_cnt++ per valid. Non-owner wait=1 throughout. When recv_cnt reaches WORDS
//   (cycle of last valid) -> IDLE next cycle, counters clear. Owner may drop req
//   after last valid; req drop mid-fill is ignored (fill always completes WORDS).
//  D_WRITE: one cycle, mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata;
//   d_data_valid=1 that cycle as store ack; i_wait=1; -> IDLE.
//  Min gap between transactions: 1 IDLE cycle. Max fill time WORDS+MEM_LAT cycles.
//  mem_data_valid outside FILL, or beyond WORDS in FILL: ignored, never forwarded.
//  Invariant: recv_cnt<=issue_cnt<=WORDS; i_data_valid&d_data_valid never both 1.
//  Reset mid-fill: -> DRAIN (not IDLE) for MEM_LAT cycles with drain counter, both
//   waits=1, valids=0, swallowing stale returns; then IDLE. Reset asserted from power-up
//   with nothing in flight behaves identically (DRAIN harmless).
//  rst dominates all other inputs in the same cycle.
// TESTING
//  1 I only: i_req=1 i_addr 0x0040..0x004E -> 8 mem_enable, 8 i_data_valid, d_wait=1.
//  2 Tie from reset: i_req=d_req=1, d_wr=0 -> D_FILL first (i_wait=1 ~12 cyc), then I.
//  3 Back-to-back ties -> grants alternate D,I,D,I; neither waits >2 fills.
//  4 Store: d_req=d_wr=1 d_addr=0x1234 d_wdata=0xBEEF -> one cycle mem_wr=1, ack, IDLE.
//  5 rst at recv_cnt=3 -> DRAIN 4 cyc, stale valids not forwarded, next fill 8 valids.
//  6 d_req drops after 2 issues -> fill still issues/returns 8; stray valid in IDLE ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache and
// D-cache fill FSMs. One requester owns the memory at a time; the owner's
// fill addresses (WORDS reads) or single store are forwarded, memory returns
// are counted and steered to the owner, and the other side is held off.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   i_req, i_addr               I-cache fill request and sequential fill address
//   d_req, d_wr, d_addr, d_wdata D-cache request; d_wr selects a 1-word store
//   mem_data_valid              read data valid from memory (MEM_LAT after issue)
//   mem_enable, mem_wr          memory access / write strobe this cycle
//   mem_addr, mem_wdata         memory address / store data
//   i_data_valid, d_data_valid  return (or store ack) steered to the owner
//   i_wait, d_wait              hold indication for the non-owner
module mem_arbiter #(
  parameter int unsigned WORDS   = 8,
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        i_wait,
  output logic        d_wait
);

  localparam logic [CNT_W-1:0] WORDS_C    = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic             last_grant_d;   // 1: D was granted most recently

  logic grant_d;    // D wins the arbitration in IDLE
  logic in_fill;
  logic issuing;
  logic accept;     // a return that belongs to the current fill
  logic last_rx;

  always_comb begin
    grant_d = d_req & (~i_req | ~last_grant_d);
    in_fill = (state == I_FILL) || (state == D_FILL);
    issuing = in_fill && (issue_cnt < WORDS_C);
    // Only returns for words already issued count; strays are dropped.
    accept  = in_fill && mem_data_valid && (recv_cnt < issue_cnt) && (recv_cnt < WORDS_C);
    last_rx = accept && (recv_cnt == LAST_WORD);
  end

  always_comb begin
    mem_enable   = issuing || (state == D_WRITE);
    mem_wr       = (state == D_WRITE);
    mem_addr     = '0;
    mem_wdata    = '0;
    i_data_valid = (state == I_FILL) && accept;
    d_data_valid = ((state == D_FILL) && accept) || (state == D_WRITE);
    i_wait       = 1'b1;
    d_wait       = 1'b1;
    if (issuing && state == I_FILL)
      mem_addr = i_addr;
    else if ((issuing && state == D_FILL) || state == D_WRITE)
      mem_addr = d_addr;
    if (state == D_WRITE)
      mem_wdata = d_wdata;
    case (state)
      IDLE: begin
        i_wait = i_req & d_req & grant_d;
        d_wait = i_req & d_req & ~grant_d;
      end
      I_FILL:  i_wait = 1'b0;
      D_FILL:  d_wait = 1'b0;
      D_WRITE: d_wait = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt    <= '0;
      recv_cnt     <= '0;
      last_grant_d <= 1'b0;
      // Reads may still be in flight: swallow their returns before IDLE.
      // A reset held across DRAIN keeps counting so it still ends.
      case (state)
        I_FILL, D_FILL: begin
          state     <= DRAIN;
          drain_cnt <= '0;
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          drain_cnt <= '0;
        end
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            last_grant_d <= grant_d;
            if (grant_d)
              state <= d_wr ? D_WRITE : D_FILL;
            else
              state <= I_FILL;
          end
        end
        I_FILL, D_FILL: begin
          if (issuing)
            issue_cnt <= issue_cnt + 1'b1;
          if (accept)
            recv_cnt <= recv_cnt + 1'b1;
          if (last_rx) begin
            state     <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
          end
        end
        D_WRITE: state <= IDLE;
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= IDLE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
